// File: rtl/dff_async_rst_if.sv
// rtl/dff_async_rst_if.sv - d/q/rst/en bundle for the enable-gated register chain
interface dff_interface #(
  parameter int unsigned WIDTH = 1
);
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output rst, output en, output d, input q);
  modport slave  (input rst, input en, input d, output q);
endinterface

// File: rtl/dff_async_rst.sv
// rtl/dff_async_rst.sv - enable-gated D register chain, synchronous active-high reset
module dff_async_rst #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      STAGES      = 1
) (
  input logic          clk,
  dff_interface.slave  bus
);
  // The initializer gives the simulation/FPGA power-up value; ASIC relies on rst.
  logic [WIDTH-1:0] stage_q [STAGES] = '{default: RESET_VALUE};
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
    end
    // One shared enable: the whole chain advances or freezes together.
    if (bus.en) begin
      stage_d[0] = bus.d;
      for (int k = 1; k < STAGES; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RESET_VALUE;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    a_rst_known: assert (!$isunknown(bus.rst));
  end

  assign bus.q = stage_q[STAGES-1];
endmodule

// File: tb/tb_dff_async_rst.sv
// tb/tb_dff_async_rst.sv - self-checking bench for dff_async_rst (1x1 and 8x3 configurations)
module tb_dff_async_rst;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  dff_interface #(.WIDTH(1)) sif ();
  dff_interface #(.WIDTH(8)) mif ();

  dff_async_rst u_single (.clk(clk), .bus(sif.slave));
  dff_async_rst #(.WIDTH(8), .RESET_VALUE(8'hA5), .STAGES(3)) u_multi (.clk(clk), .bus(mif.slave));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic rst;
    logic en;
    logic d;
    logic exp_q;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mstep(input logic rst, input logic en, input logic [7:0] d,
                       input logic [7:0] exp, input string name);
    mif.rst = rst;
    mif.en  = en;
    mif.d   = d;
    edge_step();
    check(name, mif.q, exp);
  endtask

  // Reference: the output is the sample accepted STAGES loads ago (reset preloads RESET_VALUE).
  logic       hist1 [$];
  logic [7:0] hist8 [$];

  initial begin
    sif.rst = 1'b1; sif.en = 1'b1; sif.d = 1'b1;
    mif.rst = 1'b1; mif.en = 1'b0; mif.d = 8'h00;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1};

    #1;
    check("init_single", {7'd0, sif.q}, 8'h00);
    check("init_multi", mif.q, 8'hA5);

    for (int i = 0; i < 14; i++) begin
      sif.rst = vecs[i].rst;
      sif.en  = vecs[i].en;
      sif.d   = vecs[i].d;
      edge_step();
      check($sformatf("vec%0d", i), {7'd0, sif.q}, {7'd0, vecs[i].exp_q});
    end

    // Reset pulse between edges must not touch q.
    sif.en = 1'b0; sif.d = 1'b0;
    @(posedge clk);
    #2 sif.rst = 1'b1;
    #2 sif.rst = 1'b0;
    @(negedge clk);
    check("rst_glitch_mid", {7'd0, sif.q}, 8'h01);
    edge_step();
    check("rst_glitch_after", {7'd0, sif.q}, 8'h01);

    mstep(1'b1, 1'b0, 8'h00, 8'hA5, "m_reset");
    mstep(1'b0, 1'b1, 8'h01, 8'hA5, "m_fill1");
    mstep(1'b0, 1'b1, 8'h02, 8'hA5, "m_fill2");
    mstep(1'b0, 1'b1, 8'h03, 8'h01, "m_fill3");
    mstep(1'b0, 1'b0, 8'hFF, 8'h01, "m_freeze1");
    mstep(1'b0, 1'b0, 8'hFF, 8'h01, "m_freeze2");
    mstep(1'b0, 1'b1, 8'h04, 8'h02, "m_resume");
    mstep(1'b1, 1'b1, 8'h05, 8'hA5, "m_rst_prio");
    mstep(1'b0, 1'b1, 8'h06, 8'hA5, "m_flush1");
    mstep(1'b0, 1'b1, 8'h07, 8'hA5, "m_flush2");
    mstep(1'b0, 1'b1, 8'h08, 8'h06, "m_flush3");

    for (int i = 0; i < 300; i++) begin
      logic       r1, e1, d1, r8, e8;
      logic [7:0] d8;
      r1 = (i == 0) || ($urandom_range(15) == 0);
      e1 = $urandom_range(1) == 1;
      d1 = $urandom_range(1) == 1;
      r8 = (i == 0) || ($urandom_range(15) == 0);
      e8 = $urandom_range(3) != 0;
      d8 = 8'($urandom);
      sif.rst = r1; sif.en = e1; sif.d = d1;
      mif.rst = r8; mif.en = e8; mif.d = d8;
      edge_step();
      if (r1) begin
        hist1.delete();
        hist1.push_back(1'b0);
      end else if (e1) begin
        hist1.push_back(d1);
        void'(hist1.pop_front());
      end
      if (r8) begin
        hist8.delete();
        for (int k = 0; k < 3; k++) hist8.push_back(8'hA5);
      end else if (e8) begin
        hist8.push_back(d8);
        void'(hist8.pop_front());
      end
      check($sformatf("rand_single%0d", i), {7'd0, sif.q}, {7'd0, hist1[0]});
      check($sformatf("rand_multi%0d", i), mif.q, hist8[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
